morse_disp_ctrl: RTL and testbench

Display controller that sits behind the Morse decoder top. It accepts decoded 17-bit sixteen-segment character codes through a valid/ready handshake and keeps the last DIGITS characters in a shift buffer, with the newest character rightmost. It time-multiplexes the buffer onto a single segment bus with a one-hot digit select and a blanking gap between digits to suppress ghosting. A clear input empties the buffer.

---
 rtl/morse_disp_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_morse_disp_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/morse_disp_ctrl.sv
// morse_disp_ctrl -- display controller behind the Morse decoder.
// Holds the last DIGITS decoded sixteen-segment characters (newest at digit 0),
// and time-multiplexes them onto one segment bus with a one-hot digit select.
// A blanking gap between digits suppresses ghosting.
// Optional feature: define MORSE_DISP_BLINK_EN to blink digit 0 (the newest
// character) with a half-period of BLINK_FRAMES scan frames.
`timescale 1ns/1ps

module morse_disp_ctrl #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int SEG_W        = 17,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         char_valid,
    input  logic [SEG_W-1:0]             char_seg,
    input  logic                         clear,
    output logic                         char_ready,
    output logic [SEG_W-1:0]             seg_out,
    output logic [DIGITS-1:0]            digit_sel,
    output logic [$clog2(DIGITS+1)-1:0]  count,
    output logic                         frame_tick
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int TMR_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]  ON_LAST    = TMR_W'(SCAN_DIV - 1);
    localparam logic [TMR_W-1:0]  BLANK_LAST = (BLANK_CYC > 0) ? TMR_W'(BLANK_CYC - 1) : '0;
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DIGITS);

    // Reject unusable configurations at elaboration time.
    if (DIGITS < 2 || DIGITS > 8 || SCAN_DIV < 1 || BLANK_CYC < 0 || BLINK_FRAMES < 1) begin : g_cfg_err
        $error("morse_disp_ctrl: illegal parameter combination");
    end

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } scan_st_e;

    logic [SEG_W-1:0]  disp_buf_q [DIGITS];
    logic [SEG_W-1:0]  disp_buf_d [DIGITS];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              accept;

    scan_st_e          state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              advance;
    logic              wrap;

    logic [SEG_W-1:0]  seg_out_q, seg_out_d;
    logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
    logic              frame_tick_q, frame_tick_d;

    logic              blank_digit0;

    // A pending clear always wins, so we simply refuse characters while it is high.
    assign char_ready = !clear;
    assign accept     = char_valid && char_ready;

    // Next buffer contents: clear empties it, an accept shifts the new character in at digit 0.
    always_comb begin
        disp_buf_d = disp_buf_q;
        count_d    = count_q;
        if (clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp_buf_d[i] = '0;
            end
            count_d = '0;
        end else if (accept) begin
            disp_buf_d[0] = char_seg;
            for (int i = 1; i < DIGITS; i++) begin
                disp_buf_d[i] = disp_buf_q[i-1];
            end
            if (count_q != COUNT_FULL) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Character buffer and fill count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIGITS; i++) begin
                disp_buf_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            disp_buf_q <= disp_buf_d;
            count_q    <= count_d;
        end
    end

    // Scan sequencing: drive a digit for SCAN_DIV cycles, blank for BLANK_CYC, move on.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + TMR_W'(1);
        idx_d   = idx_q;
        advance = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            ST_ON: begin
                if (tmr_q == ON_LAST) begin
                    tmr_d = '0;
                    if (BLANK_CYC == 0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                if (tmr_q == BLANK_LAST) begin
                    tmr_d   = '0;
                    state_d = ST_ON;
                    advance = 1'b1;
                end
            end
            default: begin
                tmr_d   = '0;
                state_d = ST_ON;
            end
        endcase
        if (advance) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
                wrap  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Output decode from the current scan state; registered one cycle later.
    always_comb begin
        seg_out_d    = '0;
        digit_sel_d  = '0;
        frame_tick_d = wrap;
        if (state_q == ST_ON) begin
            digit_sel_d = DIGITS'(1) << idx_q;
            seg_out_d   = disp_buf_q[idx_q];
            if (idx_q == '0 && blank_digit0) begin
                seg_out_d = '0;
            end
        end
    end

    // Scan FSM state and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ON;
            tmr_q        <= '0;
            idx_q        <= '0;
            seg_out_q    <= '0;
            digit_sel_q  <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            idx_q        <= idx_d;
            seg_out_q    <= seg_out_d;
            digit_sel_q  <= digit_sel_d;
            frame_tick_q <= frame_tick_d;
        end
    end

`ifdef MORSE_DISP_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic             blink_on_q, blink_on_d;
    logic [FRM_W-1:0] blink_frm_q, blink_frm_d;

    // Blink phase: flips every BLINK_FRAMES frame wraps; any buffer activity restarts it visible.
    always_comb begin
        blink_on_d  = blink_on_q;
        blink_frm_d = blink_frm_q;
        if (clear || accept) begin
            blink_on_d  = 1'b1;
            blink_frm_d = '0;
        end else if (wrap) begin
            if (blink_frm_q == FRM_LAST) begin
                blink_on_d  = !blink_on_q;
                blink_frm_d = '0;
            end else begin
                blink_frm_d = blink_frm_q + FRM_W'(1);
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_on_q  <= 1'b1;
            blink_frm_q <= '0;
        end else begin
            blink_on_q  <= blink_on_d;
            blink_frm_q <= blink_frm_d;
        end
    end

    assign blank_digit0 = (count_q != '0) && !blink_on_q;
`else
    assign blank_digit0 = 1'b0;
`endif

    assign seg_out    = seg_out_q;
    assign digit_sel  = digit_sel_q;
    assign count      = count_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_morse_disp_ctrl.sv
// Directed bench for morse_disp_ctrl with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
// Scan timing: sample k after reset release (k=0 first) shows digit (k/5)%4,
// blank when k%5==4; frame_tick high when k%20==19.
`timescale 1ns/1ps

module tb_morse_disp_ctrl;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLANK_CYC    = 1;
    localparam int SEG_W        = 17;
    localparam int BLINK_FRAMES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              char_valid = 1'b0;
    logic [SEG_W-1:0]  char_seg = '0;
    logic              clear = 1'b0;
    logic              char_ready;
    logic [SEG_W-1:0]  seg_out;
    logic [DIGITS-1:0] digit_sel;
    logic [2:0]        count;
    logic              frame_tick;

    int                n_tests = 0;
    int                n_fail  = 0;
    int                n       = 0;
    int                exp_cnt = 0;
    logic [SEG_W-1:0]  exp_buf [DIGITS];
`ifdef MORSE_DISP_BLINK_EN
    bit                bl_on = 1'b1;
    int                bl_wr = 0;
`endif

    always #5 clk = ~clk;

    morse_disp_ctrl #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .SEG_W       (SEG_W),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_seg   (char_seg),
        .clear      (clear),
        .char_ready (char_ready),
        .seg_out    (seg_out),
        .digit_sel  (digit_sel),
        .count      (count),
        .frame_tick (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (scan sample %0d)", tag, got, exp, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
`ifdef MORSE_DISP_BLINK_EN
        if (n >= 0 && n % 20 == 19) begin
            bl_wr++;
            if (bl_wr == BLINK_FRAMES) begin
                bl_wr = 0;
                bl_on = !bl_on;
            end
        end
`endif
    endtask

    function automatic logic [3:0] exp_sel(input int k);
        if (k % 5 == 4) return 4'b0000;
        return 4'b0001 << ((k / 5) % 4);
    endfunction

    task automatic set_exp(input logic [SEG_W-1:0] d3, input logic [SEG_W-1:0] d2,
                           input logic [SEG_W-1:0] d1, input logic [SEG_W-1:0] d0,
                           input int cnt);
        exp_buf[3] = d3;
        exp_buf[2] = d2;
        exp_buf[1] = d1;
        exp_buf[0] = d0;
        exp_cnt    = cnt;
    endtask

    task automatic restart_blink();
`ifdef MORSE_DISP_BLINK_EN
        bl_on = 1'b1;
        bl_wr = 0;
`endif
    endtask

    task automatic check_scan(input int cycles);
        logic [SEG_W-1:0] exp_seg;
        for (int c = 0; c < cycles; c++) begin
            tick();
            exp_seg = (n % 5 == 4) ? '0 : exp_buf[(n / 5) % 4];
`ifdef MORSE_DISP_BLINK_EN
            if (exp_sel(n) == 4'b0001 && exp_cnt > 0 && !bl_on) exp_seg = '0;
`endif
            chk("digit_sel", 32'(digit_sel), 32'(exp_sel(n)));
            chk("seg_out", 32'(seg_out), 32'(exp_seg));
            chk("frame_tick", 32'(frame_tick), (n % 20 == 19) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic send(input logic [SEG_W-1:0] code);
        char_valid = 1'b1;
        char_seg   = code;
        #1;
        chk("char_ready", 32'(char_ready), 32'd1);
        tick();
        char_valid = 1'b0;
        restart_blink();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        restart_blink();
        set_exp('0, '0, '0, '0, 0);
    endtask

    initial begin
        set_exp('0, '0, '0, '0, 0);

        // Reset state
        repeat (3) tick();
        chk("rst_seg_out", 32'(seg_out), 32'd0);
        chk("rst_digit_sel", 32'(digit_sel), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        chk("idle_ready", 32'(char_ready), 32'd1);
        rst = 1'b0;
        n   = -1;
        restart_blink();

        // 1: idle scan, two frames
        check_scan(40);

        // 2: three characters
        send(17'h00001);
        send(17'h00002);
        send(17'h00003);
        chk("count_three", 32'(count), 32'd3);
        set_exp(17'h0, 17'h1, 17'h2, 17'h3, 3);
        tick();
        check_scan(20);

        // 3: saturation with six characters
        do_clear();
        for (int k = 1; k <= 6; k++) begin
            send(SEG_W'(k));
            chk("count_sat", 32'(count), (k < 4) ? 32'(k) : 32'd4);
        end
        set_exp(17'h3, 17'h4, 17'h5, 17'h6, 4);
        tick();
        check_scan(20);

        // 4: clear with simultaneous char_valid
        clear      = 1'b1;
        char_valid = 1'b1;
        char_seg   = 17'h1FFFF;
        #1;
        chk("ready_on_clear", 32'(char_ready), 32'd0);
        tick();
        clear      = 1'b0;
        char_valid = 1'b0;
        restart_blink();
        chk("count_after_clear", 32'(count), 32'd0);
        set_exp('0, '0, '0, '0, 0);
        tick();
        check_scan(20);

        // 5: back-to-back accepts A, B, C
        char_valid = 1'b1;
        char_seg   = 17'h1A5A5;
        tick();
        char_seg   = 17'h0F0F0;
        tick();
        char_seg   = 17'h15555;
        tick();
        char_valid = 1'b0;
        restart_blink();
        chk("count_b2b", 32'(count), 32'd3);
        set_exp(17'h0, 17'h1A5A5, 17'h0F0F0, 17'h15555, 3);
        tick();
        check_scan(20);

`ifdef MORSE_DISP_BLINK_EN
        // 6: blinking newest digit, restored by a new accept
        do_clear();
        send(17'h0ABCD);
        set_exp('0, '0, '0, 17'h0ABCD, 1);
        check_scan(60);
        chk("blink_off_before_accept", 32'(bl_on), 32'd0);
        send(17'h00123);
        set_exp('0, '0, 17'h0ABCD, 17'h00123, 2);
        check_scan(40);
`endif

        // Reset mid-scan with a full-ish buffer
        repeat (7) tick();
        rst = 1'b1;
        tick();
        tick();
        chk("midrst_digit_sel", 32'(digit_sel), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        rst = 1'b0;
        n   = -1;
        restart_blink();
        set_exp('0, '0, '0, '0, 0);
        check_scan(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
